// File: rtl/var_byte_fifo.sv
// rtl/var_byte_fifo.sv - byte FIFO with variable-width write and pop per cycle
module var_byte_fifo #(
  parameter int FIFO_SIZE    = 128,
  parameter int MAX_WR_BYTES = 16,
  parameter int MAX_RD_BYTES = 4,
  parameter int AF_THRESH    = FIFO_SIZE - MAX_WR_BYTES,
  localparam int PW = $clog2(FIFO_SIZE),
  localparam int WB = $clog2(MAX_WR_BYTES + 1),
  localparam int RB = $clog2(MAX_RD_BYTES + 1),
  localparam int OW = $clog2(FIFO_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [MAX_WR_BYTES*8-1:0] data_in,
  input  logic                      wr_en_in,
  input  logic [WB-1:0]             wr_bytes_in,
  input  logic                      rd_en_in,
  input  logic [RB-1:0]             rd_bytes_in,
  output logic [MAX_RD_BYTES*8-1:0] data_out,
  output logic [RB-1:0]             valid_bytes_out,
  output logic                      fifo_empty_out,
  output logic                      fifo_full_out,
  output logic                      almost_full_out,
  output logic [OW-1:0]             occupancy_out,
  output logic                      wr_err_out,
  output logic                      rd_err_out
);

  logic [PW-1:0] front, back;
  logic [OW-1:0] occ;
  logic [7:0]    mem [FIFO_SIZE];

  logic          rd_ok, wr_ok;
  logic [OW-1:0] rd_acc, wr_acc, space;

  // Read is decided first; only an accepted pop frees room for the same-cycle write.
  always_comb begin
    rd_ok  = rd_en_in && (rd_bytes_in != '0) && (rd_bytes_in <= RB'(MAX_RD_BYTES))
             && (OW'(rd_bytes_in) <= occ);
    rd_acc = rd_ok ? OW'(rd_bytes_in) : '0;
    space  = OW'(FIFO_SIZE) - occ + rd_acc;
    wr_ok  = wr_en_in && (wr_bytes_in != '0) && (wr_bytes_in <= WB'(MAX_WR_BYTES))
             && (OW'(wr_bytes_in) <= space);
    wr_acc = wr_ok ? OW'(wr_bytes_in) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front      <= '0;
      back       <= '0;
      occ        <= '0;
      wr_err_out <= 1'b0;
      rd_err_out <= 1'b0;
    end else begin
      front      <= front + PW'(rd_acc);
      back       <= back + PW'(wr_acc);
      occ        <= occ + wr_acc - rd_acc;
      wr_err_out <= wr_en_in && (wr_bytes_in != '0) && !wr_ok;
      rd_err_out <= rd_en_in && (rd_bytes_in != '0) && !rd_ok;
    end
  end

  // Storage is not reset; occupancy masking hides stale bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_WR_BYTES; i++) begin
      if (wr_ok && (WB'(i) < wr_bytes_in))
        mem[back + PW'(i)] <= data_in[i*8 +: 8];
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < MAX_RD_BYTES; k++) begin
      if (OW'(k) < occ)
        data_out[k*8 +: 8] = mem[front + PW'(k)];
    end
  end

  assign valid_bytes_out = (occ >= OW'(MAX_RD_BYTES)) ? RB'(MAX_RD_BYTES) : RB'(occ);
  assign fifo_empty_out  = (occ == '0);
  assign fifo_full_out   = (occ == OW'(FIFO_SIZE));
  assign almost_full_out = (occ >= OW'(AF_THRESH));
  assign occupancy_out   = occ;

endmodule
